// File: rtl/swap_pkg.sv
// Shared types and constants for the register-swap scheduler.
package swap_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned SWAP_LAT = 5;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4,
        DONE = 3'd5
    } state_t;

    // Width of a requester id; at least one bit even for a single requester.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic idx_bad(input int unsigned idx, input int unsigned depth);
        return idx >= depth;
    endfunction

endpackage

// File: rtl/swap_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, searching upward from ptr.
module rr_arbiter
    import swap_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned PW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    logic w_found;

    // Offset i from ptr lands on slot j, with wrap-around past NREQ-1.
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        if (en) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                for (int unsigned j = 0; j < NREQ; j++) begin
                    if ((32'(ptr) + i == j) || (32'(ptr) + i == j + NREQ)) begin
                        if (!w_found && req[j]) begin
                            gnt[j]  = 1'b1;
                            w_found = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/swap_scheduler.sv
// Serialises swap requests onto one single-port register file:
// round-robin grant, then read-A, read-B, write-A, write-B.
module swap_scheduler
    import swap_pkg::*;
#(
    parameter  int unsigned NREQ  = 2,
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned IDW   = id_width(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_idx_a,
    input  logic [NREQ*AW-1:0] req_idx_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               busy,
    output logic               done,
    output logic [IDW-1:0]     done_id,
    output logic               done_err,
    output logic [AW-1:0]      rf_addr,
    output logic               rf_we,
    output logic [WIDTH-1:0]   rf_wdata,
    input  logic [WIDTH-1:0]   rf_rdata
);

    state_t           r_state, w_state_nxt;
    logic [IDW-1:0]   r_ptr, r_id, w_win, w_id_nxt;
    logic [AW-1:0]    r_idx_a, r_idx_b, w_sel_a, w_sel_b, w_a_nxt;
    logic [WIDTH-1:0] r_tmp_a;
    logic [NREQ-1:0]  w_gnt;
    logic             r_err, w_err_nxt, w_sel_bad, w_hs, w_arb_en;
    logic [AW-1:0]    w_addr_nxt;
    logic [WIDTH-1:0] w_wdata_nxt;
    logic             w_we_nxt, w_done_nxt, w_done_err_nxt;
    logic [IDW-1:0]   w_done_id_nxt;

    assign w_arb_en  = (r_state == IDLE) && !rst;
    assign req_ready = w_gnt;
    assign w_hs      = |w_gnt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (r_ptr),
        .en  (w_arb_en),
        .gnt (w_gnt)
    );

    // Winner id and its index pair.
    always_comb begin
        w_win   = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_gnt[i]) begin
                w_win   = IDW'(i);
                w_sel_a = req_idx_a[i*AW +: AW];
                w_sel_b = req_idx_b[i*AW +: AW];
            end
        end
        w_sel_bad = idx_bad(32'(w_sel_a), DEPTH) || idx_bad(32'(w_sel_b), DEPTH);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_hs) w_state_nxt = (w_sel_bad || (w_sel_a == w_sel_b)) ? DONE : RD_A;
            RD_A: w_state_nxt = RD_B;
            RD_B: w_state_nxt = WR_A;
            WR_A: w_state_nxt = WR_B;
            WR_B: w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state; rf_wdata doubles as tmp_b.
    always_comb begin
        w_a_nxt        = w_hs ? w_sel_a   : r_idx_a;
        w_id_nxt       = w_hs ? w_win     : r_id;
        w_err_nxt      = w_hs ? w_sel_bad : r_err;
        w_addr_nxt     = '0;
        w_we_nxt       = 1'b0;
        w_wdata_nxt    = '0;
        w_done_nxt     = 1'b0;
        w_done_id_nxt  = '0;
        w_done_err_nxt = 1'b0;
        case (w_state_nxt)
            RD_A: w_addr_nxt = w_a_nxt;
            RD_B: w_addr_nxt = r_idx_b;
            WR_A: begin
                w_addr_nxt  = r_idx_a;
                w_we_nxt    = 1'b1;
                w_wdata_nxt = rf_rdata;
            end
            WR_B: begin
                w_addr_nxt  = r_idx_b;
                w_we_nxt    = 1'b1;
                w_wdata_nxt = r_tmp_a;
            end
            DONE: begin
                w_done_nxt     = 1'b1;
                w_done_id_nxt  = w_id_nxt;
                w_done_err_nxt = w_err_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_idx_a  <= '0;
            r_idx_b  <= '0;
            r_err    <= 1'b0;
            r_tmp_a  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= '0;
            done_err <= 1'b0;
            rf_addr  <= '0;
            rf_we    <= 1'b0;
            rf_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_idx_a <= w_sel_a;
                r_idx_b <= w_sel_b;
                r_id    <= w_win;
                r_err   <= w_sel_bad;
                r_ptr   <= (32'(w_win) == NREQ - 1) ? '0 : w_win + IDW'(1);
            end
            if (r_state == RD_A) r_tmp_a <= rf_rdata;
            busy     <= (w_state_nxt != IDLE);
            done     <= w_done_nxt;
            done_id  <= w_done_id_nxt;
            done_err <= w_done_err_nxt;
            rf_addr  <= w_addr_nxt;
            rf_we    <= w_we_nxt;
            rf_wdata <= w_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_swap_scheduler.sv
// Bench for swap_scheduler: register-file model, swap reference model, directed and random swaps.
module tb_swap_scheduler;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_idx_a, req_idx_b;
    logic [NREQ-1:0]    req_ready;
    logic               busy, done, done_err, rf_we;
    logic [0:0]         done_id;
    logic [AW-1:0]      rf_addr;
    logic [WIDTH-1:0]   rf_wdata, rf_rdata;

    logic               e_req_valid;
    logic [2:0]         e_req_idx_a, e_req_idx_b;
    logic               e_req_ready, e_busy, e_done, e_done_err, e_rf_we;
    logic [0:0]         e_done_id;
    logic [2:0]         e_rf_addr;
    logic [WIDTH-1:0]   e_rf_wdata, e_rf_rdata;
    int                 e_writes = 0;

    logic [WIDTH-1:0]   rf_mem [8];
    logic [WIDTH-1:0]   ref_mem [8];
    logic               ld_en;
    logic [AW-1:0]      ld_addr;
    logic [WIDTH-1:0]   ld_data;
    logic [AW-1:0]      ia [NREQ];
    logic [AW-1:0]      ib [NREQ];
    int                 ref_ptr;
    int                 checks = 0;
    int                 failures = 0;

    always #5 clk = ~clk;

    swap_scheduler #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx_a(req_idx_a), .req_idx_b(req_idx_b),
        .req_ready(req_ready), .busy(busy), .done(done), .done_id(done_id), .done_err(done_err),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    swap_scheduler #(.NREQ(1), .DEPTH(6), .WIDTH(WIDTH)) dut_e (
        .clk(clk), .rst(rst), .req_valid(e_req_valid), .req_idx_a(e_req_idx_a), .req_idx_b(e_req_idx_b),
        .req_ready(e_req_ready), .busy(e_busy), .done(e_done), .done_id(e_done_id), .done_err(e_done_err),
        .rf_addr(e_rf_addr), .rf_we(e_rf_we), .rf_wdata(e_rf_wdata), .rf_rdata(e_rf_rdata)
    );

    assign rf_rdata   = rf_mem[rf_addr];
    assign e_rf_rdata = 32'h0;

    always @(posedge clk) begin
        if (ld_en) rf_mem[ld_addr] <= ld_data;
        else if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    end

    always @(posedge clk) if (e_rf_we) e_writes <= e_writes + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_idx_a[i*AW +: AW] = ia[i];
            req_idx_b[i*AW +: AW] = ib[i];
        end
    endtask

    task automatic chk_mem();
        for (int i = 0; i < 8; i++) chk("rf_contents", 64'(rf_mem[i]), 64'(ref_mem[i]));
    endtask

    // One arbitration + swap, checked cycle by cycle against the model.
    task automatic txn();
        int               exp_w;
        int               lat;
        logic             bad;
        logic [AW-1:0]    a, b;
        logic             exp_we;
        logic [AW-1:0]    exp_addr;
        logic [WIDTH-1:0] t;
        pack();
        #1;
        exp_w = -1;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (exp_w < 0 && req_valid[(ref_ptr + i) % int'(NREQ)]) exp_w = (ref_ptr + i) % int'(NREQ);
        end
        if (exp_w < 0) begin
            chk("grant_none", 64'(req_ready), 64'(0));
            @(negedge clk);
            return;
        end
        chk("grant", 64'(req_ready), 64'(1 << exp_w));
        a   = ia[exp_w];
        b   = ib[exp_w];
        bad = (32'(a) >= DEPTH) || (32'(b) >= DEPTH);
        lat = (bad || a == b) ? 1 : 5;
        @(posedge clk);
        #1 req_valid[exp_w] = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("busy", 64'(busy), 64'(1));
            chk("ready_low", 64'(req_ready), 64'(0));
            chk("done_timing", 64'(done), 64'(k == lat));
            exp_we   = (lat == 5) && (k == 3 || k == 4);
            exp_addr = (lat != 5 || k == 5) ? '0 : ((k == 1 || k == 3) ? a : b);
            chk("rf_we", 64'(rf_we), 64'(exp_we));
            chk("rf_addr", 64'(rf_addr), 64'(exp_addr));
            if (exp_we) chk("rf_wdata", 64'(rf_wdata), 64'((k == 3) ? ref_mem[b] : ref_mem[a]));
            if (k == lat) begin
                chk("done_id", 64'(done_id), 64'(exp_w));
                chk("done_err", 64'(done_err), 64'(bad));
            end
        end
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_done", 64'(done), 64'(0));
        if (lat == 5) begin
            t          = ref_mem[a];
            ref_mem[a] = ref_mem[b];
            ref_mem[b] = t;
        end
        ref_ptr = (exp_w + 1) % int'(NREQ);
        chk_mem();
    endtask

    initial begin
        logic [WIDTH-1:0] v0, v1;
        logic [1:0]       m;
        rst = 1'b1;
        req_valid = '0; req_idx_a = '0; req_idx_b = '0;
        e_req_valid = 1'b0; e_req_idx_a = '0; e_req_idx_b = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        ref_ptr = 0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_done_id", 64'(done_id), 64'(0));
        chk("rst_done_err", 64'(done_err), 64'(0));
        chk("rst_rf_addr", 64'(rf_addr), 64'(0));
        chk("rst_rf_we", 64'(rf_we), 64'(0));
        chk("rst_rf_wdata", 64'(rf_wdata), 64'(0));
        req_valid = 2'b11;
        #1 chk("rst_ready", 64'(req_ready), 64'(0));

        // Preload register file while reset holds the scheduler idle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = AW'(i);
            ld_data = (i == 2) ? 32'h11 : (i == 5) ? 32'h22 : $urandom;
            ref_mem[i] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b0;
        rst   = 1'b0;

        // Both valid from reset: req0 swap(2,5) first, then req1.
        ia[0] = 3'd2; ib[0] = 3'd5; ia[1] = 3'd0; ib[1] = 3'd7;
        txn();
        chk("swap_rf2", 64'(rf_mem[2]), 64'h22);
        chk("swap_rf5", 64'(rf_mem[5]), 64'h11);
        txn();

        // Both held valid: grants alternate.
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            txn();
            req_valid = 2'b11;
        end
        req_valid = '0;

        // a == b: immediate done, no access.
        ia[0] = 3'd3; ib[0] = 3'd3; req_valid = 2'b01;
        txn();

        // Back-to-back swap(0,1) restores the original values.
        v0 = ref_mem[0]; v1 = ref_mem[1];
        ia[0] = 3'd0; ib[0] = 3'd1; req_valid = 2'b01;
        txn();
        req_valid = 2'b01;
        txn();
        chk("restore_rf0", 64'(rf_mem[0]), 64'(v0));
        chk("restore_rf1", 64'(rf_mem[1]), 64'(v1));

        // Out-of-range index on a DEPTH=6 instance.
        e_req_idx_a = 3'd1; e_req_idx_b = 3'd7; e_req_valid = 1'b1;
        #1 chk("err_grant", 64'(e_req_ready), 64'(1));
        @(posedge clk);
        #1 e_req_valid = 1'b0;
        @(negedge clk);
        chk("err_done", 64'(e_done), 64'(1));
        chk("err_flag", 64'(e_done_err), 64'(1));
        chk("err_busy", 64'(e_busy), 64'(1));
        @(negedge clk);
        chk("err_idle_busy", 64'(e_busy), 64'(0));
        chk("err_idle_done", 64'(e_done), 64'(0));
        chk("err_writes", 64'(e_writes), 64'(0));

        // Reset during WR_A aborts the swap.
        ia[0] = 3'd4; ib[0] = 3'd6; pack(); req_valid = 2'b01;
        #1 chk("abort_grant", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("abort_in_wr_a", 64'(rf_we), 64'(1));
        chk("abort_addr", 64'(rf_addr), 64'(4));
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        chk("abort_ready", 64'(req_ready), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_done_id", 64'(done_id), 64'(0));
        chk("abort_done_err", 64'(done_err), 64'(0));
        chk("abort_rf_addr", 64'(rf_addr), 64'(0));
        chk("abort_rf_we", 64'(rf_we), 64'(0));
        chk("abort_rf_wdata", 64'(rf_wdata), 64'(0));
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            chk("abort_no_we", 64'(rf_we), 64'(0));
            chk("abort_no_done", 64'(done), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        ref_ptr = 0;
        chk_mem();
        ia[1] = 3'd4; ib[1] = 3'd6; req_valid = 2'b10;
        txn();

        // Random traffic; a held request keeps its indices until granted.
        for (int n = 0; n < 20; n++) begin
            m = 2'($urandom_range(1, 3));
            for (int i = 0; i < int'(NREQ); i++) begin
                if (m[i] && !req_valid[i]) begin
                    req_valid[i] = 1'b1;
                    ia[i] = AW'($urandom_range(0, 7));
                    ib[i] = ($urandom_range(0, 3) == 0) ? ia[i] : AW'($urandom_range(0, 7));
                end
            end
            txn();
        end
        req_valid = '0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
